// File: rtl/run_seq_pkg.sv
// Shared types and default timing constants for the accumulator-core run sequencer.
package run_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEF_HALT_PC        = 78;
    localparam int DEF_START_CYCLES   = 2;
    localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/dmem_port_mux.sv
// Owner-select mux for the single data-memory port: the host owns it while the core is parked,
// otherwise the core does.
module dmem_port_mux #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_host_own,
    input  logic                  i_host_req,
    input  logic                  i_host_we,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0] i_host_wdata,
    input  logic                  i_core_mem_re,
    input  logic                  i_core_mem_we,
    input  logic [ADDR_WIDTH-1:0] i_core_addr,
    input  logic [DATA_WIDTH-1:0] i_core_wdata,
    output logic                  o_host_gnt,
    output logic                  o_mem_re,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata
);

    always_comb begin
        o_host_gnt  = 1'b0;
        o_mem_re    = i_core_mem_re;
        o_mem_we    = i_core_mem_we;
        o_mem_addr  = i_core_addr;
        o_mem_wdata = i_core_wdata;
        if (i_host_own) begin
            // Core enables are masked so a stray core access cannot corrupt preloaded data.
            o_host_gnt  = i_host_req;
            o_mem_re    = i_host_req & ~i_host_we;
            o_mem_we    = i_host_req & i_host_we;
            o_mem_addr  = i_host_addr;
            o_mem_wdata = i_host_wdata;
        end
    end

endmodule

// File: rtl/run_sequencer.sv
// Run controller: parks the core, launches a run on go, detects halt/timeout and
// arbitrates the data-memory port between host and core.
//
// state   | meaning
// IDLE    | core parked, host owns memory, waiting for go
// START   | core held in start for START_CYCLES cycles, core owns memory
// RUN     | core executing, cycles counted, halt/timeout watched
// DONE    | run finished, flags and count held, host owns memory
module run_sequencer
    import run_seq_pkg::*;
#(
    parameter int PC_WIDTH       = 11,
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 8,
    parameter int HALT_PC        = DEF_HALT_PC,
    parameter int START_CYCLES   = DEF_START_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_go,
    input  logic                  i_host_req,
    input  logic                  i_host_we,
    input  logic [ADDR_WIDTH-1:0] i_host_addr,
    input  logic [DATA_WIDTH-1:0] i_host_wdata,
    output logic                  o_host_gnt,
    output logic [DATA_WIDTH-1:0] o_host_rdata,
    input  logic [PC_WIDTH-1:0]   i_core_pc,
    input  logic                  i_core_mem_re,
    input  logic                  i_core_mem_we,
    input  logic [ADDR_WIDTH-1:0] i_core_addr,
    input  logic [DATA_WIDTH-1:0] i_core_wdata,
    output logic                  o_core_start,
    output logic                  o_mem_re,
    output logic                  o_mem_we,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_timeout,
    output logic [CNT_WIDTH-1:0]  o_cycle_count
);

    localparam int                 SCW          = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;
    localparam logic [SCW-1:0]     START_LAST   = SCW'(START_CYCLES - 1);
    localparam logic [31:0]        HALT_PC_U    = 32'(HALT_PC);
    localparam logic [31:0]        TIMEOUT_U    = 32'(TIMEOUT_CYCLES);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [SCW-1:0]         r_start_cnt;
    logic [CNT_WIDTH-1:0]   r_cycle_count;
    logic                   r_done;
    logic                   r_timeout;
    logic                   w_launch;
    logic                   w_halt;
    logic                   w_timeout_hit;
    logic [CNT_WIDTH-1:0]   w_count_inc;
    logic                   w_host_own;

    assign w_count_inc   = (&r_cycle_count) ? r_cycle_count : r_cycle_count + 1'b1;
    assign w_halt        = 32'(i_core_pc) >= HALT_PC_U;
    // Timeout looks at the count this RUN cycle will reach, so the run lasts exactly TIMEOUT_CYCLES.
    assign w_timeout_hit = 32'(w_count_inc) >= TIMEOUT_U;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_launch     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (i_go) begin
                    w_state_next = ST_START;
                    w_launch     = 1'b1;
                end
            end
            ST_START: begin
                if (r_start_cnt == START_LAST) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_halt || w_timeout_hit) begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_start_cnt   <= '0;
            r_cycle_count <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else if (w_launch) begin
            r_start_cnt   <= '0;
            r_cycle_count <= '0;
            r_done        <= 1'b0;
            r_timeout     <= 1'b0;
        end else if (r_state == ST_START) begin
            r_start_cnt <= r_start_cnt + 1'b1;
        end else if (r_state == ST_RUN) begin
            r_cycle_count <= w_count_inc;
            if (w_halt) begin
                r_done    <= 1'b1;
                r_timeout <= 1'b0;
            end else if (w_timeout_hit) begin
                r_done    <= 1'b1;
                r_timeout <= 1'b1;
            end
        end
    end

    assign w_host_own    = (r_state == ST_IDLE) || (r_state == ST_DONE);
    assign o_core_start  = (r_state != ST_RUN);
    assign o_busy        = (r_state == ST_START) || (r_state == ST_RUN);
    assign o_done        = r_done;
    assign o_timeout     = r_timeout;
    assign o_cycle_count = r_cycle_count;
    assign o_host_rdata  = i_mem_rdata;

    dmem_port_mux #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dmem_port_mux (
        .i_host_own    (w_host_own),
        .i_host_req    (i_host_req),
        .i_host_we     (i_host_we),
        .i_host_addr   (i_host_addr),
        .i_host_wdata  (i_host_wdata),
        .i_core_mem_re (i_core_mem_re),
        .i_core_mem_we (i_core_mem_we),
        .i_core_addr   (i_core_addr),
        .i_core_wdata  (i_core_wdata),
        .o_host_gnt    (o_host_gnt),
        .o_mem_re      (o_mem_re),
        .o_mem_we      (o_mem_we),
        .o_mem_addr    (o_mem_addr),
        .o_mem_wdata   (o_mem_wdata)
    );

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: two instances (default timeout and a short 16-cycle timeout)
// share stimulus and are checked against a run-outcome model and a host memory model.
module tb_run_sequencer;

    localparam int HALT  = 78;
    localparam int T_A   = 4096;
    localparam int T_B   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic        host_req;
    logic        host_we;
    logic [7:0]  host_addr;
    logic [7:0]  host_wdata;
    logic [10:0] core_pc;
    logic        core_mem_re;
    logic        core_mem_we;
    logic [7:0]  core_addr;
    logic [7:0]  core_wdata;

    logic        a_host_gnt, a_core_start, a_mem_re, a_mem_we, a_busy, a_done, a_timeout;
    logic [7:0]  a_host_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [15:0] a_cycle_count;
    logic        b_host_gnt, b_core_start, b_mem_re, b_mem_we, b_busy, b_done, b_timeout;
    logic [7:0]  b_host_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [15:0] b_cycle_count;

    logic [7:0]  mem_a [256];
    logic [7:0]  mem_b [256];
    logic [7:0]  ref_mem [256];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign a_mem_rdata = mem_a[a_mem_addr];
    assign b_mem_rdata = mem_b[b_mem_addr];
    always @(posedge clk) if (a_mem_we) mem_a[a_mem_addr] <= a_mem_wdata;
    always @(posedge clk) if (b_mem_we) mem_b[b_mem_addr] <= b_mem_wdata;

    run_sequencer #(.TIMEOUT_CYCLES(T_A)) dut_a (
        .i_clk(clk), .i_reset(reset), .i_go(go),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
        .o_host_gnt(a_host_gnt), .o_host_rdata(a_host_rdata),
        .i_core_pc(core_pc), .i_core_mem_re(core_mem_re), .i_core_mem_we(core_mem_we),
        .i_core_addr(core_addr), .i_core_wdata(core_wdata),
        .o_core_start(a_core_start), .o_mem_re(a_mem_re), .o_mem_we(a_mem_we),
        .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata), .i_mem_rdata(a_mem_rdata),
        .o_busy(a_busy), .o_done(a_done), .o_timeout(a_timeout), .o_cycle_count(a_cycle_count)
    );

    run_sequencer #(.TIMEOUT_CYCLES(T_B)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_go(go),
        .i_host_req(host_req), .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
        .o_host_gnt(b_host_gnt), .o_host_rdata(b_host_rdata),
        .i_core_pc(core_pc), .i_core_mem_re(core_mem_re), .i_core_mem_we(core_mem_we),
        .i_core_addr(core_addr), .i_core_wdata(core_wdata),
        .o_core_start(b_core_start), .o_mem_re(b_mem_re), .o_mem_we(b_mem_we),
        .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata),
        .o_busy(b_busy), .o_done(b_done), .o_timeout(b_timeout), .o_cycle_count(b_cycle_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run outcome from first principles: a run lasts until the halt cycle or the timeout,
    // whichever comes first; a halt on the timeout cycle is still a halt.
    function automatic int exp_count(input int h, input int t);
        return (h <= t) ? h : t;
    endfunction

    function automatic logic exp_to(input int h, input int t);
        return (h > t);
    endfunction

    task automatic check_parked(input string tag);
        check({tag, " a_busy"},   a_busy, 0);
        check({tag, " a_start"},  a_core_start, 1);
        check({tag, " a_done"},   a_done, 0);
        check({tag, " a_to"},     a_timeout, 0);
        check({tag, " a_count"},  a_cycle_count, 0);
        check({tag, " b_busy"},   b_busy, 0);
        check({tag, " b_count"},  b_cycle_count, 0);
        check({tag, " b_start"},  b_core_start, 1);
    endtask

    // h: RUN cycle on which core_pc reaches HALT; abort_at: RUN cycle on which reset is raised (0 = never)
    task automatic do_run(input int h, input int abort_at);
        logic [7:0] wd;
        go = 1'b1;
        #1;
        check("pre-go core_start", a_core_start, 1);
        tick();
        go = 1'b0;
        check("start1 busy", a_busy, 1);
        check("start1 core_start", a_core_start, 1);
        check("start1 done cleared", a_done, 0);
        check("start1 count cleared", a_cycle_count, 0);
        check("start1 b count cleared", b_cycle_count, 0);
        go = 1'b1;
        tick();
        go = 1'b0;
        check("start2 core_start", a_core_start, 1);
        check("start2 b busy", b_busy, 1);
        tick();
        for (int k = 1; k <= h; k++) begin
            core_pc = (k == h) ? 11'(HALT + $urandom_range(0, 100)) : 11'($urandom_range(0, HALT - 1));
            if (k == 1) begin
                check("run core_start low", a_core_start, 0);
                check("run b core_start low", b_core_start, 0);
            end
            if (k == abort_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                core_pc = '0;
                check_parked("abort");
                return;
            end
            if (k == 3) begin
                wd = 8'($urandom);
                host_req = 1'b1; host_we = 1'b1; host_addr = 8'($urandom);
                core_mem_we = 1'b1; core_addr = 8'h20; core_wdata = wd;
                #1;
                check("run host_gnt", a_host_gnt, 0);
                check("run mem_we core", a_mem_we, 1);
                check("run mem_addr core", a_mem_addr, 8'h20);
                check("run mem_wdata core", a_mem_wdata, wd);
            end
            tick();
            host_req = 1'b0; host_we = 1'b0; core_mem_we = 1'b0;
        end
        core_pc = '0;
        check("end a done", a_done, 1);
        check("end a timeout", a_timeout, exp_to(h, T_A));
        check("end a count", a_cycle_count, exp_count(h, T_A));
        check("end a core_start", a_core_start, 1);
        check("end a busy", a_busy, 0);
        check("end b done", b_done, 1);
        check("end b timeout", b_timeout, exp_to(h, T_B));
        check("end b count", b_cycle_count, exp_count(h, T_B));
        host_req = 1'b1; host_we = 1'b0;
        #1;
        check("done host_gnt", a_host_gnt, 1);
        host_req = 1'b0;
    endtask

    initial begin
        logic [7:0] addrs [8];
        logic [7:0] wd;
        reset = 1'b1; go = 1'b0; host_req = 1'b0; host_we = 1'b0;
        host_addr = '0; host_wdata = '0; core_pc = '0;
        core_mem_re = 1'b0; core_mem_we = 1'b0; core_addr = '0; core_wdata = '0;
        repeat (2) tick();
        check_parked("reset");
        reset = 1'b0;
        tick();

        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h00;
        #1;
        check("idle host_gnt", a_host_gnt, 1);
        tick();

        host_we = 1'b1; host_addr = 8'h10; host_wdata = 8'hA5;
        core_mem_we = 1'b1; core_addr = 8'h33; core_wdata = 8'h5A;
        #1;
        check("idle wr mem_we", a_mem_we, 1);
        check("idle wr mem_addr", a_mem_addr, 8'h10);
        check("idle wr mem_wdata", a_mem_wdata, 8'hA5);
        tick();
        ref_mem[8'h10] = 8'hA5;
        host_req = 1'b0;
        #1;
        check("idle core we masked", a_mem_we, 0);
        check("idle core re masked", a_mem_re, 0);
        core_mem_we = 1'b0;
        host_req = 1'b1; host_we = 1'b0; host_addr = 8'h10;
        #1;
        check("idle rd mem_re", a_mem_re, 1);
        check("idle rd rdata", a_host_rdata, 8'hA5);
        tick();

        for (int i = 0; i < 8; i++) begin
            addrs[i] = 8'($urandom);
            wd = 8'($urandom);
            host_req = 1'b1; host_we = 1'b1; host_addr = addrs[i]; host_wdata = wd;
            ref_mem[addrs[i]] = wd;
            tick();
        end
        for (int i = 7; i >= 0; i--) begin
            host_req = 1'b1; host_we = 1'b0; host_addr = addrs[i];
            #1;
            check("rand readback", a_host_rdata, ref_mem[addrs[i]]);
            tick();
        end
        host_req = 1'b0;

        do_run(50, 0);
        do_run(16, 0);
        do_run(17, 0);
        do_run(30, 0);
        do_run(40, 10);
        tick();
        do_run(5, 0);
        for (int r = 0; r < 6; r++) begin
            do_run($urandom_range(1, 60), 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/run_sequencer.md
Name: run_sequencer

Overview:
Run controller for the single-cycle 9-bit accumulator core. It holds the core parked through its start input, lets a host preload and read back data memory, launches a run on a go pulse, and detects halt (PC past the end address) or timeout. It also arbitrates the single data-memory port between host and core, and reports done, timeout and cycle count to the bench/host.

Parameters:
PC_WIDTH, 11, core program-counter width
ADDR_WIDTH, 8, data-memory address width
DATA_WIDTH, 8, data-memory word width
HALT_PC, 78, run ends when core_pc >= HALT_PC
START_CYCLES, 2, cycles core_start is held high before a run (>=1)
TIMEOUT_CYCLES, 4096, maximum RUN cycles before forced stop
CNT_WIDTH, 16, cycle_count width

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
go  in  1  single-cycle pulse; launches a run from IDLE or DONE
host_req  in  1  host memory access request
host_we  in  1  host write (1) / read (0)
host_addr  in  ADDR_WIDTH  host address
host_wdata  in  DATA_WIDTH  host write data
host_gnt  out  1  host access accepted this cycle
host_rdata  out  DATA_WIDTH  read data (=mem_rdata)
core_pc  in  PC_WIDTH  core program counter
core_mem_re  in  1  core read enable
core_mem_we  in  1  core write enable
core_addr  in  ADDR_WIDTH  core address
core_wdata  in  DATA_WIDTH  core write data
core_start  out  1  drives core start (1 = held/reset)
mem_re  out  1  to data_mem read_enabled
mem_we  out  1  to data_mem write_enabled
mem_addr  out  ADDR_WIDTH  to data_mem addr
mem_wdata  out  DATA_WIDTH  to data_mem data_to_write
mem_rdata  in  DATA_WIDTH  from data_mem data_out (combinational read)
busy  out  1  state is START or RUN
done  out  1  run finished (halt or timeout)
timeout  out  1  run ended by timeout
cycle_count  out  CNT_WIDTH  RUN cycles of last/current run

Behaviour:
- Reset (sync, high): state=IDLE, core_start=1, done=0, timeout=0, busy=0, cycle_count=0, start counter=0. Reset mid-run aborts; IDLE on the next edge.
- States: IDLE, START, RUN, DONE. core_start=1 in all states except RUN.
- IDLE: go -> START; start counter cleared; cycle_count cleared; done/timeout cleared.
- START: held exactly START_CYCLES cycles, then -> RUN. go is ignored.
- RUN: cycle_count += 1 every RUN cycle, including the terminating cycle; saturates at all-ones. go is ignored.
  - core_pc >= HALT_PC -> DONE, done=1, timeout=0.
  - Else cycle_count reaching TIMEOUT_CYCLES on this cycle -> DONE, done=1, timeout=1.
  - Halt and timeout in the same cycle: halt wins, timeout=0.
- DONE: done, timeout and cycle_count hold. go -> START with the same clears as IDLE.
- Arbitration (combinational):
  - IDLE/DONE: host owns the port. host_gnt=host_req; mem_re=host_req&~host_we; mem_we=host_req&host_we; addr/wdata from host. Core enables are masked.
  - START/RUN: core owns the port. host_gnt=0 (host must hold its request); mem_re/mem_we/addr/wdata from core. Core enables in START pass through but are harmless because the core is held.
  - go and host_req in the same IDLE cycle: the host access completes that cycle; state moves to START on the edge.
  - host_rdata=mem_rdata at all times.
- Outputs done, timeout, busy and cycle_count are registered or derived from registered state only. There is no combinational path from core_pc to done.

Decomposition:
- Package run_seq_pkg: state enum (IDLE, START, RUN, DONE), default HALT_PC/TIMEOUT_CYCLES/START_CYCLES constants.
- Sub-module dmem_port_mux: combinational owner-select mux of host vs core memory signals, with host_gnt. The FSM, counters and flags stay in run_sequencer.

Test Plan:
- Reset held 2 cycles -> state IDLE, core_start=1, done=0, timeout=0, cycle_count=0. host_req=1 then gives host_gnt=1.
- IDLE host write addr 0x10 data 0xA5, then read 0x10 -> mem_we=1, mem_addr=0x10 on the write; host_rdata=0xA5 on the read. core_mem_we=1 in IDLE -> mem_we follows host only.
- go pulse -> core_start=1 for 2 cycles, then 0. core_pc=78 driven on RUN cycle 50 -> DONE next edge, done=1, timeout=0, cycle_count=50, core_start=1.
- host_req=1 during RUN with core_mem_we=1, core_addr=0x20 -> host_gnt=0, mem_we=1, mem_addr=0x20. After DONE, host_gnt=1.
- TIMEOUT_CYCLES=16, core_pc fixed at 5 -> DONE after 16 RUN cycles, done=1, timeout=1, cycle_count=16. Variant with core_pc=78 on cycle 16 -> timeout=0.
- reset asserted on RUN cycle 10 -> IDLE next edge, cycle_count=0, core_start=1. A later go from DONE reruns with cycle_count restarting at 0.
